// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory access stage: address select, handshaked read/write, MDR, timeout
module mem_access_unit #(
    parameter int DW      = 12,
    parameter int AW      = 12,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [1:0]    mem_src,
    input  logic [AW-1:0] pc,
    input  logic [AW-1:0] ea,
    input  logic [AW-1:0] ir_addr,
    input  logic [DW-1:0] wdata,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic          m_re,
    output logic          m_we,
    input  logic          m_ready,
    input  logic [DW-1:0] m_rdata,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, FIN} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          re_q, we_q, busy_q, done_q, err_q;
    logic          err_d;
    logic [AW-1:0] mdr_addr;
    logic [AW-1:0] sel_addr;

    // The MDR doubles as the pointer for indirect addressing.
    generate
        if (DW >= AW) begin : g_mdr_trunc
            assign mdr_addr = rdata_q[AW-1:0];
        end else begin : g_mdr_zext
            assign mdr_addr = {{(AW-DW){1'b0}}, rdata_q};
        end
    endgenerate

    always_comb begin
        sel_addr = pc;
        case (mem_src)
            2'b00: sel_addr = pc;
            2'b01: sel_addr = ea;
            2'b10: sel_addr = ir_addr;
            2'b11: sel_addr = mdr_addr;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_write) begin
                    addr_d  = sel_addr;
                    wdata_d = wdata;
                    cnt_d   = '0;
                    state_d = WR_WAIT;
                end else if (mem_read) begin
                    addr_d  = sel_addr;
                    cnt_d   = '0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                // A late m_ready on the final allowed cycle still wins over the timeout.
                if (m_ready) begin
                    if (state_q == RD_WAIT) begin
                        rdata_d = m_rdata;
                    end
                    state_d = FIN;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            re_q    <= (state_d == RD_WAIT);
            we_q    <= (state_d == WR_WAIT);
            busy_q  <= (state_d == RD_WAIT) || (state_d == WR_WAIT);
            done_q  <= (state_d == FIN);
            err_q   <= err_d;
        end
    end

    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign m_re    = re_q;
    assign m_we    = we_q;
    assign rdata   = rdata_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side stage directly downstream of the PDP control unit.
- Consumes the control unit's mem_read, mem_write and mem_src strobes, selects the address, and runs one handshaked access to a variable-latency memory.
- Latches read data into an internal MDR and reports busy/done/err, so the datapath can stall and then load IR, EA or ACC.

Parameters:
DW, 12, data word width (PDP word)
AW, 12, address width
TIMEOUT, 15, max wait cycles for m_ready before abort (1..255)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
mem_read  input  1  read request from control unit
mem_write  input  1  write request from control unit
mem_src  input  2  address select: 00 pc, 01 ea, 10 ir_addr, 11 mdr (indirect)
pc  input  AW  program counter
ea  input  AW  effective address register
ir_addr  input  AW  address field of instruction register
wdata  input  DW  store data (ACC or PC+1, chosen upstream)
m_addr  output  AW  memory address
m_wdata  output  DW  memory write data
m_re  output  1  memory read strobe
m_we  output  1  memory write strobe
m_ready  input  1  memory completion, sampled only while waiting
m_rdata  input  DW  memory read data, valid with m_ready
rdata  output  DW  MDR contents
busy  output  1  access in progress (stall)
done  output  1  one-cycle completion pulse
err  output  1  one-cycle timeout pulse, coincident with done

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; m_addr, m_wdata, rdata and the wait counter are 0; m_re, m_we, busy, done and err are 0. Reset aborts any access in flight; the memory sees strobes drop on the next cycle.
- States:
  - IDLE: accepts a request.
  - RD_WAIT / WR_WAIT: hold the strobe until m_ready or timeout.
  - FIN: one cycle; done=1.
- IDLE, mem_write=1 at edge:
  - Latch m_addr from mem_src and m_wdata=wdata; clear counter; go to WR_WAIT.
  - Write has priority when mem_read and mem_write are both 1.
- IDLE, mem_read=1 only: latch m_addr; go to RD_WAIT.
- Address mux uses current inputs at acceptance. mem_src=11 uses the current rdata, which is the indirect pointer.
- Addresses wider than AW are not possible. The mdr select uses rdata[AW-1:0], zero-extended if DW<AW.
- Wait states:
  - m_re=1 (or m_we=1) for every cycle in the state.
  - m_addr and m_wdata are stable throughout.
  - Counter increments each cycle without m_ready.
- m_ready=1 in RD_WAIT: rdata<=m_rdata at that edge; go to FIN.
- m_ready=1 in WR_WAIT: go to FIN; rdata unchanged.
- Counter reaches TIMEOUT with no m_ready: go to FIN with err=1; rdata unchanged; strobes drop.
- m_ready in the same cycle the counter hits TIMEOUT counts as success (no err).
- FIN: strobes 0, done=1, busy=0; return to IDLE next cycle. Requests in FIN are ignored; the control unit must re-present them in IDLE.
- busy=1 in RD_WAIT and WR_WAIT only; it goes high the cycle after acceptance.
- Latency:
  - Request sampled at edge N; strobe high in cycle N+1.
  - m_ready seen at edge N+k (k≥1) gives done in cycle N+k+1.
  - Minimum 2 cycles, request to done.
- m_ready in IDLE or FIN is ignored.
- All outputs are registered; no combinational path from inputs to m_* outputs.

Test Plan:
1. Reset, then read with mem_src=00, pc=12'o0200, m_ready after 3 wait cycles, m_rdata=12'o1234 -> m_addr=0200, m_re high 3 cycles, rdata=1234, done pulse 1 cycle, busy high exactly 3 cycles.
2. Write with mem_src=01, ea=12'o0377, wdata=12'o7001, m_ready in first wait cycle -> m_we 1 cycle, m_wdata=7001, done 2 cycles after request, rdata unchanged.
3. Indirect: read from ir_addr=12'o0050 returns 12'o0600, then read with mem_src=11 -> second m_addr=0600.
4. mem_read and mem_write both 1 in IDLE -> write cycle only, m_re never asserted.
5. TIMEOUT=4, m_ready held 0 -> m_re high 4 cycles, then done=1 with err=1, rdata unchanged; m_ready arriving on the 4th cycle -> no err.
6. rst_n low during RD_WAIT -> next cycle IDLE, m_re=0, rdata=0, no done; a request held in FIN is ignored and not serviced.
